// File: rtl/instruction_loader.sv
// instruction_loader: accepts 32-bit program words over a valid/ready
// handshake and writes each one as four big-endian bytes at consecutive
// addresses of the byte-wide instruction store.
module instruction_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic [ADDR_W-1:0] BaseAddr,
   input  logic [31:0]       WordIn,
   input  logic              WordValid,
   input  logic              LastWord,
   output logic              WordReady,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [7:0]        MemData,
   output logic              MemWre,
   output logic              Busy,
   output logic              Done,
   output logic              Overflow
);

   typedef enum logic [1:0] {IDLE, WAIT_WORD, WRITE, DONE} state_t;

   localparam logic [ADDR_W-1:0] PTR_MAX = '1;
   localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t            state, state_nx;
   logic [ADDR_W-1:0] ptr;
   logic [31:0]       word;
   logic              last;
   logic [1:0]        idx;

   // State register; reset drops every decoded output without a clock edge.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Next-state and output decode; outputs depend on registers only.
   always_comb begin
      state_nx  = state;
      WordReady = 1'b0;
      MemWre    = 1'b0;
      Busy      = 1'b0;
      Done      = 1'b0;
      MemAddr   = ptr;
      case (idx)
         2'd0:    MemData = word[31:24];
         2'd1:    MemData = word[23:16];
         2'd2:    MemData = word[15:8];
         default: MemData = word[7:0];
      endcase
      case (state)
         IDLE: begin
            if (Start) state_nx = WAIT_WORD;
         end
         WAIT_WORD: begin
            WordReady = 1'b1;
            Busy      = 1'b1;
            if (WordValid) state_nx = WRITE;
         end
         WRITE: begin
            MemWre = 1'b1;
            Busy   = 1'b1;
            if (idx == 2'd3) state_nx = last ? DONE : WAIT_WORD;
         end
         DONE: begin
            Done = 1'b1;
            if (Start) state_nx = WAIT_WORD;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: session setup, word capture, byte pointer walk and wrap flag.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         ptr      <= '0;
         word     <= '0;
         last     <= 1'b0;
         idx      <= 2'd0;
         Overflow <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (Start) begin
                  ptr      <= BaseAddr;
                  Overflow <= 1'b0;
               end
            end
            WAIT_WORD: begin
               if (WordValid) begin
                  word <= WordIn;
                  last <= LastWord;
                  idx  <= 2'd0;
               end
            end
            WRITE: begin
               // Pointer wraps modulo the store size; the write still happens.
               ptr <= ptr + PTR_ONE;
               idx <= idx + 2'd1;
               if (ptr == PTR_MAX) Overflow <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader with a byte-write scoreboard.
module tb_instruction_loader;

   logic        clk = 1'b0;
   logic        Reset;
   logic        Start;
   logic [7:0]  BaseAddr;
   logic [31:0] WordIn;
   logic        WordValid;
   logic        LastWord;
   logic        WordReady;
   logic [7:0]  MemAddr;
   logic [7:0]  MemData;
   logic        MemWre;
   logic        Busy;
   logic        Done;
   logic        Overflow;

   int          chk = 0;
   int          err = 0;
   int          wr_cnt = 0;
   logic [7:0]  mptr = 8'h00;
   logic        ovf_exp = 1'b0;
   logic        ovf_arm = 1'b0;
   logic [15:0] q[$];

   instruction_loader #(.ADDR_W(8)) dut (
      .clk(clk), .Reset(Reset), .Start(Start), .BaseAddr(BaseAddr),
      .WordIn(WordIn), .WordValid(WordValid), .LastWord(LastWord),
      .WordReady(WordReady), .MemAddr(MemAddr), .MemData(MemData),
      .MemWre(MemWre), .Busy(Busy), .Done(Done), .Overflow(Overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk++;
      assert (obs === exp) else begin
         err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wre"},   {31'd0, MemWre},    32'd0);
      check({tag, "_addr"},  {24'd0, MemAddr},   32'd0);
      check({tag, "_data"},  {24'd0, MemData},   32'd0);
      check({tag, "_ready"}, {31'd0, WordReady}, 32'd0);
      check({tag, "_busy"},  {31'd0, Busy},      32'd0);
      check({tag, "_done"},  {31'd0, Done},      32'd0);
      check({tag, "_ovf"},   {31'd0, Overflow},  32'd0);
   endtask

   // One clock; afterwards any presented byte write is checked against the scoreboard.
   task automatic step();
      logic [15:0] e;
      @(posedge clk);
      if (ovf_arm) begin ovf_exp = 1'b1; ovf_arm = 1'b0; end
      #1;
      if (!Reset) begin
         check("overflow", {31'd0, Overflow}, {31'd0, ovf_exp});
         if (MemWre) begin
            wr_cnt++;
            check("ready_in_write", {31'd0, WordReady}, 32'd0);
            check("busy_in_write", {31'd0, Busy}, 32'd1);
            check("sb_nonempty", {31'd0, (q.size() > 0)}, 32'd1);
            if (q.size() > 0) begin
               e = q.pop_front();
               check("wr_addr", {24'd0, MemAddr}, {24'd0, e[15:8]});
               check("wr_data", {24'd0, MemData}, {24'd0, e[7:0]});
               if (e[15:8] == 8'hFF) ovf_arm = 1'b1;
            end
         end
      end
   endtask

   task automatic start(input logic [7:0] b);
      Start = 1'b1; BaseAddr = b;
      mptr = b; ovf_exp = 1'b0; ovf_arm = 1'b0;
      step();
      Start = 1'b0;
      check("start_ready", {31'd0, WordReady}, 32'd1);
      check("start_busy",  {31'd0, Busy},      32'd1);
      check("start_done",  {31'd0, Done},      32'd0);
   endtask

   task automatic send_word(input logic [31:0] w, input logic lw, input int gap, input bit mid_start);
      int n;
      int w0;
      if (gap > 0) begin
         WordValid = 1'b0;
         repeat (gap) step();
      end
      WordIn = w; LastWord = lw; WordValid = 1'b1;
      n = 0;
      while (WordReady !== 1'b1 && n < 20) begin step(); n++; end
      check("handshake_ready", {31'd0, WordReady}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         q.push_back({mptr, w[31-8*i -: 8]});
         mptr = mptr + 8'd1;
      end
      w0 = wr_cnt;
      step();                 // handshake edge -> write cycle 1
      step();                 // write cycle 2
      if (mid_start) begin Start = 1'b1; BaseAddr = 8'h80; end
      step();                 // write cycle 3
      Start = 1'b0;
      step();                 // write cycle 4
      check("write_burst", wr_cnt - w0, 32'd4);
      if (lw) WordValid = 1'b0;
      step();                 // H+5
      check("after_ready", {31'd0, WordReady}, {31'd0, !lw});
      check("after_busy",  {31'd0, Busy},      {31'd0, !lw});
      check("after_done",  {31'd0, Done},      {31'd0, lw});
      check("after_wre",   {31'd0, MemWre},    32'd0);
      check("sb_drained",  q.size(),           32'd0);
   endtask

   initial begin
      Reset = 1'b1; Start = 1'b0; BaseAddr = 8'h00;
      WordIn = 32'h0; WordValid = 1'b0; LastWord = 1'b0;
      #2;
      check_all_zero("reset_async");
      repeat (2) @(posedge clk);
      #1 Reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         check_all_zero("idle_hold");
      end

      // single word
      start(8'h10);
      send_word(32'h8C010004, 1'b1, 0, 1'b0);
      check("single_ovf", {31'd0, Overflow}, 32'd0);

      // back-pressure, WordValid held through the first gap-free word
      start(8'h00);
      send_word(32'h11223344, 1'b0, 0, 1'b0);
      send_word(32'h55667788, 1'b0, 3, 1'b0);
      send_word(32'h99AABBCC, 1'b1, 1, 1'b0);

      // wrap past 0xFF
      start(8'hFE);
      send_word(32'hAABBCCDD, 1'b0, 2, 1'b0);
      send_word(32'h01020304, 1'b1, 0, 1'b0);
      check("wrap_ovf_done", {31'd0, Overflow}, 32'd1);
      repeat (2) step();
      check("wrap_ovf_held", {31'd0, Overflow}, 32'd1);

      // Start during WRITE ignored; Start in DONE restarts
      start(8'h30);
      check("ovf_cleared", {31'd0, Overflow}, 32'd0);
      send_word(32'hCAFEF00D, 1'b1, 0, 1'b1);
      start(8'h80);
      send_word(32'h0BADC0DE, 1'b1, 0, 1'b0);

      // reset after the second byte has been captured
      start(8'h20);
      WordIn = 32'hDEADBEEF; LastWord = 1'b1; WordValid = 1'b1;
      check("rst_ready", {31'd0, WordReady}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         q.push_back({mptr, WordIn[31-8*i -: 8]});
         mptr = mptr + 8'd1;
      end
      wr_cnt = 0;
      step();                 // write 0xDE
      step();                 // write 0xAD
      @(posedge clk);         // 0xAD captured
      #1 Reset = 1'b1;
      WordValid = 1'b0;
      ovf_exp = 1'b0; ovf_arm = 1'b0;
      #1;
      check_all_zero("reset_midwrite");
      check("rst_bytes_written", wr_cnt, 32'd2);
      check("rst_bytes_dropped", q.size(), 32'd2);
      q.delete();
      step();
      step();
      Reset = 1'b0;
      step();
      check_all_zero("post_reset_idle");
      start(8'h40);
      send_word(32'h12345678, 1'b1, 0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", chk, err);
      $finish;
   end

endmodule
